core_if: RTL

- Instruction-fetch stage of the i2d core, directly upstream of core_id.
- Owns the fetch PC and issues word reads on a req/ack instruction-memory port.
- Buffers returned words in a small prefetch FIFO and presents the FIFO head to core_id as if_pc/if_instr.
- Drives if_busy to throttle core_id, and discards in-flight and buffered fetches on a branch redirect.

---
 rtl/core_if_pkg.sv | 24 ++
 rtl/core_if_fifo.sv | 66 ++++++
 rtl/core_if.sv | 132 +++++++++++++
 3 files changed

// File: rtl/core_if_pkg.sv
// Shared fetch/decode types: opcode constants, instruction word, fetch FSM
// states and the prefetch FIFO entry layout.
package core_if_pkg;

  localparam int unsigned CORE_OPCODE_WIDTH = 6;
  localparam logic [CORE_OPCODE_WIDTH-1:0] OPCODE_NOP = 6'h13;

  typedef logic [31:0] instr_t;

  localparam instr_t INSTR_NOP = {OPCODE_NOP, {(32-CORE_OPCODE_WIDTH){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    instr_t      instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/core_if_fifo.sv
// Prefetch FIFO for core_if: DEPTH entries, clear beats push/pop, and a
// simultaneous push+pop while full is accepted.
module core_if_fifo
  import core_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q < CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/core_if.sv
// Instruction fetch stage: owns the fetch PC, runs the imem req/ack port and
// presents the prefetch FIFO head to core_id.
module core_if
  import core_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        id_halt,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_busy,
  output logic        if_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          req_q, req_d;
  logic [31:0]   target;
  logic          push, pop, empty, space, slot_after;
  logic [CW-1:0] count;
  fetch_entry_t  head, entry_in;

  core_if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (branch_valid),
    .din   (entry_in),
    .head  (head),
    .count (count)
  );

  always_comb begin
    target     = branch_target & ~32'h3;
    empty      = (count == '0);
    if_busy    = empty | id_halt | branch_valid;
    pop        = !if_busy;
    push       = (state_q == REQ) && imem_ack && !branch_valid;
    space      = (count < CW'(DEPTH)) || pop;
    slot_after = (count + CW'(push) - CW'(pop)) < CW'(DEPTH);
    entry_in   = '{pc: addr_q, instr: (imem_err ? INSTR_NOP : imem_rdata), fault: imem_err};

    if_pc     = empty ? last_pc_q : head.pc;
    if_instr  = empty ? INSTR_NOP : head.instr;
    if_fault  = !empty && head.fault;
    last_pc_d = if_pc;
  end

  // fetch_pc always names the outstanding (or next) access; a redirect from
  // IDLE is issued straight to the target to keep the latency at one cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    unique case (state_q)
      IDLE: begin
        if (branch_valid) begin
          fetch_pc_d = target;
          addr_d     = target;
          req_d      = 1'b1;
          state_d    = REQ;
        end else if (space) begin
          addr_d  = fetch_pc_q;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack && branch_valid) begin
          fetch_pc_d = target;
          req_d      = 1'b0;
          state_d    = IDLE;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (slot_after) begin
            addr_d = fetch_pc_q + 32'd4;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (branch_valid) begin
          fetch_pc_d = target;
          state_d    = DROP;
        end
      end
      DROP: begin
        if (branch_valid) fetch_pc_d = target;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      last_pc_q  <= last_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

endmodule
